id_hazard_ctrl: RTL and testbench

//  Parametrised ID-stage hazard controller for the 5-stage MIPS pipeline.
//  - Detects load-use hazards against NLD downstream load stages, with an $zero exemption.
//  - Freezes the pipeline while data memory is busy.
//  - Sequences HALT through a counted pipeline drain into a sticky halted state.
//  - Gates branch flushes and keeps a saturating stall-cycle counter for the debug unit.

---
 rtl/mips_pkg.sv | 13 +
 rtl/id_load_use_cmp.sv | 23 ++
 rtl/id_hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_id_hazard_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: register-number width default and the
// ID-stage hazard controller FSM encoding.
package mips_pkg;

    localparam int RNBITS_DEF = 5;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } hz_state_t;

endpackage

// File: rtl/id_load_use_cmp.sv
// One load destination compared against the ID operands. A load into $zero
// never creates a dependency, so rt==0 can never produce a hit.
module id_load_use_cmp
    import mips_pkg::*;
#(
    parameter int RNBITS = RNBITS_DEF
) (
    input  logic              i_valid,
    input  logic [RNBITS-1:0] i_ld_rt,
    input  logic [RNBITS-1:0] i_id_rs,
    input  logic [RNBITS-1:0] i_id_rt,
    input  logic              i_uses_rt,
    output logic              o_hit
);

    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = (i_ld_rt == i_id_rs);
    assign w_rt_match = i_uses_rt && (i_ld_rt == i_id_rt);
    assign o_hit      = i_valid && (i_ld_rt != '0) && (w_rs_match || w_rt_match);

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: load-use bubbles, memory-busy freeze, branch
// flush gating, HALT drain sequencing and a saturating stall counter.
module id_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int RNBITS  = RNBITS_DEF,
    parameter int NLD     = 2,
    parameter int DRAIN   = 4,
    parameter int CNTBITS = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [NLD-1:0]        i_ld_valid,
    input  logic [NLD*RNBITS-1:0] i_ld_rt,
    input  logic [RNBITS-1:0]     i_id_rs,
    input  logic [RNBITS-1:0]     i_id_rt,
    input  logic                  i_id_uses_rt,
    input  logic                  i_jalr,
    input  logic                  i_halt,
    input  logic                  i_flush,
    input  logic                  i_mem_busy,
    output logic                  o_mux_risk,
    output logic                  o_pc_write,
    output logic                  o_if_id_write,
    output logic                  o_latch_flush,
    output logic                  o_freeze,
    output logic                  o_halted,
    output logic [CNTBITS-1:0]    o_stall_cnt
);

    localparam int DCW = $clog2(DRAIN + 1);

    hz_state_t        r_state;
    hz_state_t        w_next_state;
    logic [DCW-1:0]   r_dcnt;
    logic [DCW-1:0]   w_next_dcnt;
    logic             r_halted;
    logic [CNTBITS-1:0] r_stall_cnt;
    logic [NLD-1:0]   w_hit;
    logic             w_lu;
    logic             w_halt_take;
    logic             w_stall_inc;

    genvar k;
    generate
        for (k = 0; k < NLD; k++) begin : g_cmp
            id_load_use_cmp #(
                .RNBITS(RNBITS)
            ) u_cmp (
                .i_valid  (i_ld_valid[k]),
                .i_ld_rt  (i_ld_rt[k*RNBITS +: RNBITS]),
                .i_id_rs  (i_id_rs),
                .i_id_rt  (i_id_rt),
                .i_uses_rt(i_id_uses_rt),
                .o_hit    (w_hit[k])
            );
        end
    endgenerate

    // Deeper load stages only matter for JR/JALR, which consume rs in ID.
    always_comb begin
        w_lu = w_hit[0];
        for (int i = 1; i < NLD; i++) begin
            w_lu = w_lu | (w_hit[i] & i_jalr);
        end
    end

    always_comb begin
        o_mux_risk    = 1'b0;
        o_pc_write    = 1'b1;
        o_if_id_write = 1'b1;
        o_latch_flush = 1'b0;
        o_freeze      = 1'b0;
        w_halt_take   = 1'b0;
        if (i_reset) begin
            o_mux_risk    = 1'b1;
            o_pc_write    = 1'b0;
            o_if_id_write = 1'b0;
            o_latch_flush = 1'b1;
        end else if (r_state == ST_HALTED) begin
            o_mux_risk    = 1'b1;
            o_pc_write    = 1'b0;
            o_if_id_write = 1'b0;
        end else if (i_mem_busy) begin
            o_pc_write    = 1'b0;
            o_if_id_write = 1'b0;
            o_freeze      = 1'b1;
        end else if (i_flush) begin
            o_latch_flush = 1'b1;
        end else if (r_state == ST_DRAIN) begin
            o_mux_risk = 1'b1;
            o_pc_write = 1'b0;
        end else if (w_lu) begin
            o_mux_risk    = 1'b1;
            o_pc_write    = 1'b0;
            o_if_id_write = 1'b0;
        end else if (i_halt) begin
            o_pc_write  = 1'b0;
            w_halt_take = 1'b1;
        end
    end

    // A busy memory holds the whole sequencer; nothing advances until it clears.
    always_comb begin
        w_next_state = r_state;
        w_next_dcnt  = r_dcnt;
        if (!i_mem_busy) begin
            case (r_state)
                ST_RUN: begin
                    if (w_halt_take) begin
                        w_next_state = ST_DRAIN;
                        w_next_dcnt  = DCW'(DRAIN - 1);
                    end
                end
                ST_DRAIN: begin
                    if (i_flush) begin
                        w_next_state = ST_RUN;
                        w_next_dcnt  = '0;
                    end else if (r_dcnt == '0) begin
                        w_next_state = ST_HALTED;
                    end else begin
                        w_next_dcnt = r_dcnt - DCW'(1);
                    end
                end
                default: begin
                    w_next_state = r_state;
                end
            endcase
        end
    end

    assign w_stall_inc = !o_pc_write && (r_state == ST_RUN || r_state == ST_DRAIN);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_RUN;
            r_dcnt      <= '0;
            r_halted    <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state  <= w_next_state;
            r_dcnt   <= w_next_dcnt;
            r_halted <= (w_next_state == ST_HALTED);
            if (w_stall_inc && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign o_halted    = r_halted;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: load-use, HALT drain, flush squash,
// memory-busy freeze and stall counter saturation with hand-computed values.
module tb_id_hazard_ctrl;

    localparam int RNB = 5;
    localparam int NL  = 2;
    localparam int DR  = 4;
    localparam int CB  = 4;

    // control vector order: {mux_risk, pc_write, if_id_write, latch_flush, freeze}
    localparam logic [4:0] CTL_RUN    = 5'b01100;
    localparam logic [4:0] CTL_LU     = 5'b10000;
    localparam logic [4:0] CTL_HALT   = 5'b00100;
    localparam logic [4:0] CTL_DRAIN  = 5'b10100;
    localparam logic [4:0] CTL_HALTED = 5'b10000;
    localparam logic [4:0] CTL_FLUSH  = 5'b01110;
    localparam logic [4:0] CTL_BUSY   = 5'b00001;
    localparam logic [4:0] CTL_RESET  = 5'b10010;

    logic              clk = 1'b0;
    logic              reset;
    logic [NL-1:0]     ldValid;
    logic [NL*RNB-1:0] ldRt;
    logic [RNB-1:0]    idRs;
    logic [RNB-1:0]    idRt;
    logic              usesRt;
    logic              jalr;
    logic              halt;
    logic              flush;
    logic              memBusy;
    logic              muxRisk;
    logic              pcWrite;
    logic              ifIdWrite;
    logic              latchFlush;
    logic              freeze;
    logic              halted;
    logic [CB-1:0]     stallCnt;

    int nAsserts = 0;
    int nFails   = 0;

    id_hazard_ctrl #(
        .RNBITS (RNB),
        .NLD    (NL),
        .DRAIN  (DR),
        .CNTBITS(CB)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_ld_valid   (ldValid),
        .i_ld_rt      (ldRt),
        .i_id_rs      (idRs),
        .i_id_rt      (idRt),
        .i_id_uses_rt (usesRt),
        .i_jalr       (jalr),
        .i_halt       (halt),
        .i_flush      (flush),
        .i_mem_busy   (memBusy),
        .o_mux_risk   (muxRisk),
        .o_pc_write   (pcWrite),
        .o_if_id_write(ifIdWrite),
        .o_latch_flush(latchFlush),
        .o_freeze     (freeze),
        .o_halted     (halted),
        .o_stall_cnt  (stallCnt)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [1:0] v, input logic [4:0] rt1, input logic [4:0] rt0,
                                 input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                                 input logic jr, input logic hl, input logic fl, input logic bz);
        ldValid = v;
        ldRt    = {rt1, rt0};
        idRs    = rs;
        idRt    = rt;
        usesRt  = ur;
        jalr    = jr;
        halt    = hl;
        flush   = fl;
        memBusy = bz;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkCtl(input string tag, input logic [4:0] expected);
        checkOutput(tag, {27'd0, muxRisk, pcWrite, ifIdWrite, latchFlush, freeze}, {27'd0, expected});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        checkCtl("reset_ctl", CTL_RESET);
        tick();
        tick();
        checkOutput("reset_halted", {31'd0, halted}, 32'd0);
        checkOutput("reset_cnt", {28'd0, stallCnt}, 32'd0);

        // load-use on stage 0 via rs, then via rt
        reset = 1'b0;
        idle();
        checkCtl("run_idle", CTL_RUN);
        tick();
        applyStimulus(2'b01, 5'd0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCtl("lu_rs", CTL_LU);
        tick();
        idle();
        checkCtl("lu_release", CTL_RUN);
        checkOutput("lu_cnt1", {28'd0, stallCnt}, 32'd1);
        tick();
        applyStimulus(2'b01, 5'd0, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCtl("lu_rt", CTL_LU);
        tick();
        applyStimulus(2'b01, 5'd0, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCtl("lu_rt_unused", CTL_RUN);
        tick();

        // $zero exemption and deep-stage checks only for JR/JALR
        applyStimulus(2'b01, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCtl("zero_exempt", CTL_RUN);
        tick();
        applyStimulus(2'b10, 5'd7, 5'd0, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkCtl("stage1_jalr", CTL_LU);
        tick();
        applyStimulus(2'b10, 5'd7, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCtl("stage1_nojalr", CTL_RUN);
        tick();
        checkOutput("cnt_after_lu", {28'd0, stallCnt}, 32'd3);

        // HALT drain: halted rises DRAIN+1 cycles after HALT is seen
        applyStimulus(2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkCtl("halt_accept", CTL_HALT);
        tick();
        idle();
        for (int c = 1; c <= DR; c++) begin
            checkCtl("drain_ctl", CTL_DRAIN);
            checkOutput("drain_not_halted", {31'd0, halted}, 32'd0);
            tick();
        end
        checkOutput("halted_rise", {31'd0, halted}, 32'd1);
        checkCtl("halted_ctl", CTL_HALTED);
        checkOutput("drain_cnt", {28'd0, stallCnt}, 32'd8);
        for (int c = 0; c < 20; c++) begin
            tick();
            checkOutput("halted_sticky", {31'd0, halted}, 32'd1);
        end
        applyStimulus(2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkCtl("halted_over_busy", CTL_HALTED);
        tick();
        checkOutput("halted_cnt_frozen", {28'd0, stallCnt}, 32'd8);

        // flush in drain cycle 2 squashes the HALT
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
        applyStimulus(2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        applyStimulus(2'b01, 5'd0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkCtl("drain_flush", CTL_FLUSH);
        tick();
        idle();
        checkCtl("flush_back_run", CTL_RUN);
        for (int c = 0; c < 8; c++) begin
            tick();
            checkOutput("flush_no_halt", {31'd0, halted}, 32'd0);
        end
        checkOutput("flush_cnt", {28'd0, stallCnt}, 32'd2);

        // mem_busy during lu+flush, then the flush lands without a bubble
        for (int c = 0; c < 3; c++) begin
            applyStimulus(2'b01, 5'd0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            checkCtl("busy_freeze", CTL_BUSY);
            tick();
        end
        applyStimulus(2'b01, 5'd0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCtl("busy_then_flush", CTL_FLUSH);
        tick();
        checkOutput("busy_cnt", {28'd0, stallCnt}, 32'd5);

        // mem_busy inside drain holds the drain counter
        applyStimulus(2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            checkCtl("drain_busy", CTL_BUSY);
            tick();
        end
        idle();
        for (int c = 0; c < DR; c++) begin
            checkCtl("drain_after_busy", CTL_DRAIN);
            checkOutput("drain_held", {31'd0, halted}, 32'd0);
            tick();
        end
        checkOutput("drain_busy_halted", {31'd0, halted}, 32'd1);
        checkOutput("drain_busy_cnt", {28'd0, stallCnt}, 32'd13);

        // counter saturation, then reset in the middle of a drain
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(2'b01, 5'd0, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        checkOutput("cnt_saturate", {28'd0, stallCnt}, 32'd15);
        applyStimulus(2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        checkOutput("cnt_stays_sat", {28'd0, stallCnt}, 32'd15);
        reset = 1'b1;
        #1;
        checkCtl("reset_mid_drain", CTL_RESET);
        tick();
        reset = 1'b0;
        idle();
        checkOutput("abort_cnt", {28'd0, stallCnt}, 32'd0);
        checkOutput("abort_halted", {31'd0, halted}, 32'd0);
        checkCtl("abort_run", CTL_RUN);
        for (int c = 0; c < 6; c++) begin
            tick();
            checkOutput("abort_no_halt", {31'd0, halted}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
